// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous SRAM between the instruction-fetch port
// (read-only) and the data load/store port, so a single memory image holds
// both program and data.
//
// At most one SRAM access is issued per cycle. The issue decision is
// combinational; read data comes back from the SRAM one cycle later and is
// routed to the port that issued it, together with a one-cycle ack pulse.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ack)
//   i_ack/i_rdata       fetch ack pulse and fetched word
//   d_req/d_we/d_be/    data request (held until d_ack), store flag,
//   d_addr/d_wdata      store byte enables, address, store data
//   d_ack/d_rdata       data ack pulse, load data (0 on a store ack)
//   mem_en/mem_we/      SRAM strobe, write enable, byte enables,
//   mem_be/mem_addr/    address and write data
//   mem_wdata
//   mem_rdata           SRAM read data, valid the cycle after a read strobe
//
// Build option:
//   ARB_RR_EN  when defined, ties are broken round-robin using a one-bit
//              last-winner register; otherwise data always beats fetch.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch port
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    // data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    // SRAM port
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    // Owner of the access issued in the previous cycle (i.e. whose response
    // is on mem_rdata this cycle).
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    logic [1:0] r_owner;
    logic [1:0] w_owner_next;
    logic       r_d_store;      // outstanding data access is a store

    logic w_i_elig;
    logic w_d_elig;
    logic w_issue_i;
    logic w_issue_d;
    logic w_prio_d;             // data wins a tie this cycle

    // A port whose response is due this cycle still has its req high for
    // the old transaction, so it must not be issued again. Reset blocks
    // every issue.
    assign w_i_elig  = !reset && i_req && (r_owner != OWN_I);
    assign w_d_elig  = !reset && d_req && (r_owner != OWN_D);
    assign w_issue_d = w_d_elig && (!w_i_elig || w_prio_d);
    assign w_issue_i = w_i_elig && !w_issue_d;

`ifdef ARB_RR_EN
    // 1 = data won the most recent issue. Resets to "fetch won" so the
    // first tie goes to data.
    logic r_last_d;

    assign w_prio_d = !r_last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (w_issue_i || w_issue_d) begin
            r_last_d <= w_issue_d;
        end
    end
`else
    assign w_prio_d = 1'b1;
`endif

    // ---------------------------------------------------------------------
    // Owner state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    // Remember whether the data access was a store so its ack returns 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_store <= 1'b0;
        end else if (w_issue_d) begin
            r_d_store <= d_we;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic: owner lasts exactly one cycle after the issue.
    // ---------------------------------------------------------------------
    always_comb begin
        w_owner_next = OWN_NONE;
        if (w_issue_d) begin
            w_owner_next = OWN_D;
        end else if (w_issue_i) begin
            w_owner_next = OWN_I;
        end
    end

    // ---------------------------------------------------------------------
    // Output logic: SRAM request and response routing
    // ---------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_issue_d) begin
            mem_en   = 1'b1;
            mem_we   = d_we;
            mem_addr = d_addr;
            if (d_we) begin
                mem_be    = d_be;
                mem_wdata = d_wdata;
            end else begin
                mem_be    = {BE_W{1'b1}};
            end
        end else if (w_issue_i) begin
            mem_en   = 1'b1;
            mem_be   = {BE_W{1'b1}};
            mem_addr = i_addr;
        end
    end

    // The owner register only clears at the reset edge, so the response
    // must also be suppressed combinationally while reset is high.
    always_comb begin
        i_ack   = 1'b0;
        i_rdata = '0;
        d_ack   = 1'b0;
        d_rdata = '0;
        if (!reset) begin
            if (r_owner == OWN_I) begin
                i_ack   = 1'b1;
                i_rdata = mem_rdata;
            end
            if (r_owner == OWN_D) begin
                d_ack = 1'b1;
                if (!r_d_store) begin
                    d_rdata = mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter: a 64-word SRAM model, directed scenarios
// with literal expectations, and a randomized reactive phase. A transaction
// level model (who was served last cycle, a shadow copy of memory) is checked
// against the DUT on every cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // SRAM model (64 words, word index = addr[7:2])
    // ---------------------------------------------------------------------
    logic [31:0] sram   [0:63];
    logic [31:0] shadow [0:63];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[7:2]];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Reference model and per-cycle comparison.
    // m_last: 0 none, 1 fetch, 2 data was served in the previous cycle.
    // ---------------------------------------------------------------------
    int          m_last   = 0;
    logic [31:0] m_data   = '0;
    bit          m_last_d = 1'b0;

    always @(negedge clk) begin : cmp
        int          w;
        bit          ie, de, pd;
        logic [31:0] e_be, e_addr;
        if (reset) begin
            chk("rst_i_ack",   i_ack,   0);
            chk("rst_d_ack",   d_ack,   0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_mem_en",  mem_en,  0);
            m_last   = 0;
            m_last_d = 1'b0;
        end else begin
            chk("i_ack",   i_ack,   (m_last == 1));
            chk("d_ack",   d_ack,   (m_last == 2));
            chk("i_rdata", i_rdata, (m_last == 1) ? m_data : 32'h0);
            chk("d_rdata", d_rdata, (m_last == 2) ? m_data : 32'h0);
            ie = i_req && (m_last != 1);
            de = d_req && (m_last != 2);
`ifdef ARB_RR_EN
            pd = !m_last_d;
`else
            pd = 1'b1;
`endif
            if (de && (!ie || pd)) w = 2;
            else if (ie)           w = 1;
            else                   w = 0;
            e_be   = (w == 2 && d_we) ? {28'h0, d_be} : ((w != 0) ? 32'hF : 32'h0);
            e_addr = (w == 2) ? d_addr : ((w == 1) ? i_addr : 32'h0);
            chk("mem_en",   mem_en,   (w != 0));
            chk("mem_we",   mem_we,   (w == 2) && d_we);
            chk("mem_be",   mem_be,   e_be);
            chk("mem_addr", mem_addr, e_addr);
            if (w == 0)              chk("mem_wdata_idle",  mem_wdata, 0);
            else if (w == 2 && d_we) chk("mem_wdata_store", mem_wdata, d_wdata);
            if (w == 2 && d_we) begin
                for (int b = 0; b < BW; b++)
                    if (d_be[b]) shadow[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
                m_data = 32'h0;
            end else if (w == 2) begin
                m_data = shadow[d_addr[7:2]];
            end else if (w == 1) begin
                m_data = shadow[i_addr[7:2]];
            end
            if (w != 0) m_last_d = (w == 2);
            m_last = w;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (all enter and leave at posedge + 1)
    // ---------------------------------------------------------------------
    task automatic d_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd);
        bit got = 1'b0;
        rd = 32'hx;
        d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk); #1;
            if (d_ack) begin got = 1'b1; rd = d_rdata; end
            else begin @(posedge clk); #1; end
        end
        if (!got) chk("d_ack_timeout", d_ack, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic drain();
        bit ia, da;
        for (int k = 0; k < 8 && (i_req || d_req); k++) begin
            @(negedge clk); #1;
            ia = i_ack; da = d_ack;
            @(posedge clk); #1;
            if (ia) i_req = 1'b0;
            if (da) d_req = 1'b0;
        end
        if (i_req) chk("drain_i_ack_timeout", i_ack, 1);
        if (d_req) chk("drain_d_ack_timeout", d_ack, 1);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        return a;
    endfunction

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin : stim
        logic [31:0] rd, v;
        int ni, nd, nboth, nen;
        bit ia, da;

        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            sram[i] = v; shadow[i] = v;
        end
        sram[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_i_ack", i_ack, 0);
        chk("reset_mem_en", mem_en, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fetch only: issue in cycle 0, ack in cycle 1 with no re-issue
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk); #1;
        chk("fetch_issue_en", mem_en, 1);
        chk("fetch_issue_addr", mem_addr, 32'h10);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("fetch_ack", i_ack, 1);
        chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
        chk("fetch_no_reissue", mem_en, 0);
        @(posedge clk); #1;
        i_req = 1'b0;

        // Store then load, full word and single byte
        d_access(1'b1, 4'hF, 32'h20, 32'h12345678, rd);
        chk("store_ack_rdata", rd, 32'h0);
        d_access(1'b0, 4'hF, 32'h20, 32'h0, rd);
        chk("load_after_store", rd, 32'h12345678);
        d_access(1'b1, 4'hF, 32'h24, 32'hFFFFFFFF, rd);
        d_access(1'b1, 4'h1, 32'h24, 32'h12345678, rd);
        d_access(1'b0, 4'hF, 32'h24, 32'h0, rd);
        chk("byte_store_load", rd, 32'hFFFFFF78);

        // Simultaneous requests: first tie goes to data in both builds
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h30;
        @(negedge clk); #1;
        chk("tie1_winner_addr", mem_addr, 32'h30);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("tie1_d_ack", d_ack, 1);
        chk("tie1_i_issue_addr", mem_addr, 32'h40);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk); #1;
        chk("tie1_i_ack", i_ack, 1);
        chk("tie1_no_d_ack", d_ack, 0);
        @(posedge clk); #1;
        i_req = 1'b0;

        // Gap containing a lone data access, then the same tie again
        @(posedge clk); #1;
        d_access(1'b1, 4'hF, 32'h50, 32'hA5A5A5A5, rd);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h30;
        @(negedge clk); #1;
`ifdef ARB_RR_EN
        chk("tie2_winner_addr_rr", mem_addr, 32'h40);
`else
        chk("tie2_winner_addr_fixed", mem_addr, 32'h30);
`endif
        @(posedge clk); #1;
        drain();

        // Sustained contention: both re-request immediately after each ack
        ni = 0; nd = 0; nboth = 0; nen = 0;
        i_req = 1'b1; i_addr = raddr();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = raddr();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            ia = i_ack; da = d_ack;
            if (mem_en) nen++;
            if (ia) ni++;
            if (da) nd++;
            if (ia && da) nboth++;
            @(posedge clk); #1;
            if (ia) i_addr = raddr();
            if (da) begin
                d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
                d_addr = raddr(); d_wdata = $urandom;
            end
        end
        chk("contention_mem_en_cycles", nen, 20);
        chk("contention_i_count_ok", (ni >= 9 && ni <= 11), 1);
        chk("contention_d_count_ok", (nd >= 9 && nd <= 11), 1);
        chk("contention_both_acks", nboth, 0);
        drain();

        // Reset in the ack cycle of a load
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h20;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_mid_d_ack", d_ack, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_reissue_en", mem_en, 1);
        chk("rst_reissue_addr", mem_addr, 32'h20);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("rst_reissue_ack", d_ack, 1);
        chk("rst_reissue_rdata", d_rdata, 32'h12345678);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk); #1;
        chk("rst_single_ack", d_ack, 0);
        @(posedge clk); #1;

        // Randomized reactive phase, with occasional reset pulses
        for (int c = 0; c < 800; c++) begin
            @(negedge clk); #1;
            ia = i_ack; da = d_ack;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 99) == 0);
            if (!i_req || ia) begin
                if ($urandom_range(0, 1) == 1) begin
                    i_req = 1'b1; i_addr = raddr();
                end else begin
                    i_req = 1'b0;
                end
            end
            if (!d_req || da) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_be = 4'($urandom_range(0, 15)); d_addr = raddr(); d_wdata = $urandom;
                end else begin
                    d_req = 1'b0;
                end
            end
        end
        reset = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
